// File: rtl/l1_cache_pkg.sv
// Shared L1 cache constants, address split and refill FSM state encoding.
package l1_cache_pkg;

    localparam int unsigned TAG_W  = 23;
    localparam int unsigned SET_W  = 4;
    localparam int unsigned WORD_W = 3;
    localparam int unsigned OFF_W  = 2;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SET_W-1:0]  set;
        logic [WORD_W-1:0] word;
        logic [OFF_W-1:0]  off;
    } cache_addr_t;

    function automatic cache_addr_t split_addr(input logic [31:0] addr);
        return cache_addr_t'(addr);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// Single-word read port between the refill controller and memory.
interface l1_refill_ctrl_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/l1_victim_sel.sv
// Victim choice: lowest-index invalid line, otherwise the round-robin pointer.
module l1_victim_sel #(
    parameter  int unsigned NLINES = 8,
    localparam int unsigned IDX_W  = $clog2(NLINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NLINES-1:0] line_valid,
    input  logic              fill_done,
    input  logic [IDX_W-1:0]  fill_idx,
    output logic [IDX_W-1:0]  victim
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic             found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else if (fill_done) begin
            // NLINES is a power of two, so the add wraps modulo NLINES.
            rr_ptr_q <= fill_idx + IDX_W'(1);
        end
    end

    always_comb begin
        victim = rr_ptr_q;
        found  = 1'b0;
        for (int unsigned i = 0; i < NLINES; i++) begin
            if (!line_valid[i] && !found) begin
                victim = IDX_W'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_refill_ctrl.sv
// L1 miss handler: owns per-line valid/tag/set, detects read misses and
// refills the victim line with an in-order 8-word burst from memory.
module l1_refill_ctrl
    import l1_cache_pkg::*;
#(
    parameter  int unsigned NLINES = 8,
    localparam int unsigned IDX_W  = $clog2(NLINES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_rreq,
    input  logic                    cpu_wreq,
    input  logic [31:0]             cpu_addr,
    input  logic [NLINES-1:0]       line_hit,
    input  logic                    inval,
    output logic                    cpu_stall,
    output logic [NLINES-1:0]       line_valid,
    output logic [NLINES*TAG_W-1:0] line_tag,
    output logic [NLINES*SET_W-1:0] line_set,
    output logic                    fill_active,
    output logic [NLINES-1:0]       fill_wreq,
    output logic [31:0]             fill_addr,
    output logic [31:0]             fill_wdata,
    output logic [3:0]              fill_wmask,
    l1_refill_ctrl_if.master        mem
);

    fill_state_e                   state_q, state_d;
    logic [NLINES-1:0]             valid_q;
    logic [NLINES-1:0][TAG_W-1:0]  tags_q;
    logic [NLINES-1:0][SET_W-1:0]  sets_q;
    logic [WORD_W-1:0]             cnt_q;
    logic [IDX_W-1:0]              vic_q;
    logic [IDX_W-1:0]              victim;
    logic                          inval_pend_q;

    logic        miss, clr_all, start_fill, beat, fill_done;
    cache_addr_t cpu_a;
    logic        unused_ok;

    assign cpu_a     = split_addr(cpu_addr);
    assign unused_ok = ^{cpu_wreq, cpu_a.word, cpu_a.off};

    l1_victim_sel #(.NLINES(NLINES)) u_victim (
        .clk        (clk),
        .reset      (reset),
        .line_valid (valid_q),
        .fill_done  (fill_done),
        .fill_idx   (vic_q),
        .victim     (victim)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A deferred invalidate is treated like a live one, so it also holds off a coincident miss.
    always_comb begin
        miss       = cpu_rreq & ~|line_hit;
        clr_all    = (state_q == IDLE) & (inval | inval_pend_q);
        start_fill = (state_q == IDLE) & miss & ~clr_all;
        beat       = (state_q == FILL) & mem.mem_ack;
        fill_done  = beat & (cnt_q == '1);
        state_d    = state_q;
        fill_wreq  = '0;
        cpu_stall  = miss;
        case (state_q)
            IDLE: if (start_fill) state_d = FILL;
            FILL: begin
                cpu_stall = 1'b1;
                if (beat)      fill_wreq[vic_q] = 1'b1;
                if (fill_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            tags_q       <= '0;
            sets_q       <= '0;
            cnt_q        <= '0;
            vic_q        <= '0;
            inval_pend_q <= 1'b0;
        end else begin
            if (clr_all) begin
                valid_q      <= '0;
                inval_pend_q <= 1'b0;
            end
            if ((state_q == FILL) && inval) inval_pend_q <= 1'b1;
            if (start_fill) begin
                valid_q[victim] <= 1'b0;
                tags_q[victim]  <= cpu_a.tag;
                sets_q[victim]  <= cpu_a.set;
                vic_q           <= victim;
                cnt_q           <= '0;
            end
            if (beat)      cnt_q <= cnt_q + WORD_W'(1);
            if (fill_done) valid_q[vic_q] <= 1'b1;
        end
    end

    assign line_valid   = valid_q;
    assign line_tag     = tags_q;
    assign line_set     = sets_q;
    assign fill_active  = (state_q == FILL);
    assign fill_addr    = {tags_q[vic_q], sets_q[vic_q], cnt_q, {OFF_W{1'b0}}};
    assign fill_wdata   = mem.mem_rdata;
    assign fill_wmask   = 4'hF;
    assign mem.mem_req  = (state_q == FILL);
    assign mem.mem_addr = fill_addr;

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl with a behavioural line-unit array and wait-state memory.
module tb_l1_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rreq, cpu_wreq, inval;
    logic [31:0] cpu_addr;
    logic [7:0]  line_hit;
    logic        cpu_stall;
    logic [7:0]  line_valid;
    logic [8*23-1:0] line_tag;
    logic [8*4-1:0]  line_set;
    logic        fill_active;
    logic [7:0]  fill_wreq;
    logic [31:0] fill_addr, fill_wdata;
    logic [3:0]  fill_wmask;

    int          waits = 0;
    logic        ack_force = 1'b0;
    logic [3:0]  wcnt;
    int          n_checks = 0;
    int          n_errors = 0;

    l1_refill_ctrl_if mif ();

    l1_refill_ctrl #(.NLINES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_rreq    (cpu_rreq),
        .cpu_wreq    (cpu_wreq),
        .cpu_addr    (cpu_addr),
        .line_hit    (line_hit),
        .inval       (inval),
        .cpu_stall   (cpu_stall),
        .line_valid  (line_valid),
        .line_tag    (line_tag),
        .line_set    (line_set),
        .fill_active (fill_active),
        .fill_wreq   (fill_wreq),
        .fill_addr   (fill_addr),
        .fill_wdata  (fill_wdata),
        .fill_wmask  (fill_wmask),
        .mem         (mif.master)
    );

    always #5 clk = ~clk;

    // Memory: acks after `waits` idle cycles per word, data 0xA0 + word index.
    assign mif.mem_ack   = (mif.mem_req && (wcnt == 4'(waits))) || ack_force;
    assign mif.mem_rdata = 32'hA0 + {29'd0, mif.mem_addr[4:2]};

    always @(posedge clk or negedge reset) begin
        if (!reset)                           wcnt <= '0;
        else if (mif.mem_req && !mif.mem_ack) wcnt <= wcnt + 4'd1;
        else                                  wcnt <= '0;
    end

    // Line units: hit on valid and matching tag/set.
    always_comb begin
        line_hit = '0;
        for (int i = 0; i < 8; i++)
            line_hit[i] = line_valid[i] && (line_tag[i*23 +: 23] == cpu_addr[31:9])
                          && (line_set[i*4 +: 4] == cpu_addr[8:5]);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input logic [31:0] addr, input int exp_v, input int exp_cycles,
                            input logic [7:0] valid_during);
        int          cyc   = 0;
        int          words = 0;
        logic [31:0] exp_a;
        logic [7:0]  onehot;
        onehot   = 8'(1) << exp_v;
        cpu_rreq = 1'b1;
        cpu_addr = addr;
        #1;
        chk("miss_stall", {63'd0, cpu_stall}, 64'd1);
        step();
        for (int t = 0; t < 200 && mif.mem_req; t++) begin
            cyc++;
            exp_a = (addr & ~32'h1F) | 32'(words << 2);
            chk("fill_active", {63'd0, fill_active}, 64'd1);
            chk("stall_fill", {63'd0, cpu_stall}, 64'd1);
            chk("valid_during", {56'd0, line_valid}, {56'd0, valid_during});
            chk("mem_addr", {32'd0, mif.mem_addr}, {32'd0, exp_a});
            chk("fill_addr", {32'd0, fill_addr}, {32'd0, exp_a});
            chk("fill_wreq", {56'd0, fill_wreq}, mif.mem_ack ? {56'd0, onehot} : 64'd0);
            if (mif.mem_ack) begin
                chk("fill_wdata", {32'd0, fill_wdata}, 64'hA0 + 64'(words));
                words++;
            end
            step();
        end
        chk("fill_cycles", 64'(cyc), 64'(exp_cycles));
        chk("valid_after", {56'd0, line_valid}, {56'd0, valid_during | onehot});
        chk("stall_after", {63'd0, cpu_stall}, 64'd0);
        chk("req_after", {63'd0, mif.mem_req}, 64'd0);
        cpu_rreq = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        cpu_rreq = 1'b0;
        cpu_wreq = 1'b0;
        inval    = 1'b0;
        cpu_addr = '0;
        step();
        step();
        chk("rst_valid", {56'd0, line_valid}, 64'd0);
        chk("rst_req", {63'd0, mif.mem_req}, 64'd0);
        chk("rst_wreq", {56'd0, fill_wreq}, 64'd0);
        chk("rst_active", {63'd0, fill_active}, 64'd0);
        chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
        chk("rst_wmask", {60'd0, fill_wmask}, 64'hF);
        reset = 1'b1;
        step();

        // 1: first miss, zero-wait memory, line 0
        run_fill(32'h0000_1040, 0, 8, 8'h00);
        chk("tag0", {41'd0, line_tag[22:0]}, 64'h8);
        chk("set0", {60'd0, line_set[3:0]}, 64'h2);

        // 2: fill remaining lines, then round-robin victims 0 and 1
        for (int i = 1; i < 8; i++)
            run_fill(32'h0000_1040 + 32'(i << 9), i, 8, 8'((1 << i) - 1));
        run_fill(32'h0000_9040, 0, 8, 8'hFE);
        run_fill(32'h0000_B040, 1, 8, 8'hFD);

        // 3: three wait cycles per word
        waits = 3;
        run_fill(32'h0000_D040, 2, 32, 8'hFB);
        waits = 0;

        // 4: inval in IDLE beats a coincident miss; inval during word 3 is deferred
        cpu_rreq = 1'b1;
        cpu_addr = 32'h0000_1040;
        inval    = 1'b1;
        step();
        chk("inval_idle_valid", {56'd0, line_valid}, 64'd0);
        chk("inval_idle_req", {63'd0, mif.mem_req}, 64'd0);
        inval = 1'b0;
        #1;
        chk("inval_remiss_stall", {63'd0, cpu_stall}, 64'd1);
        step();
        for (int k = 0; k < 8; k++) begin
            inval = (k == 3);
            #1;
            chk("inval_fill_wreq", {56'd0, fill_wreq}, 64'h01);
            chk("inval_fill_addr", {32'd0, mif.mem_addr}, 64'h1040 + 64'(k * 4));
            step();
        end
        inval = 1'b0;
        #1;
        chk("pend_valid_one", {56'd0, line_valid}, 64'h01);
        chk("pend_stall", {63'd0, cpu_stall}, 64'd0);
        cpu_rreq = 1'b0;
        step();
        chk("pend_valid_clr", {56'd0, line_valid}, 64'h00);
        chk("pend_req", {63'd0, mif.mem_req}, 64'd0);

        // 5: reset during word 5 of a fill, then restart from word 0
        run_fill(32'h0000_3040, 0, 8, 8'h00);
        cpu_rreq = 1'b1;
        cpu_addr = 32'h0000_5040;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("pre_rst_wreq", {56'd0, fill_wreq}, 64'h02);
            step();
        end
        chk("pre_rst_addr", {32'd0, mif.mem_addr}, 64'h5054);
        reset = 1'b0;
        #1;
        chk("midrst_req", {63'd0, mif.mem_req}, 64'd0);
        chk("midrst_valid", {56'd0, line_valid}, 64'd0);
        chk("midrst_active", {63'd0, fill_active}, 64'd0);
        step();
        step();
        reset = 1'b1;
        run_fill(32'h0000_5040, 0, 8, 8'h00);

        // 6: write to uncached address, plus a stray ack while idle
        cpu_wreq  = 1'b1;
        cpu_addr  = 32'h0000_7000;
        ack_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wr_req", {63'd0, mif.mem_req}, 64'd0);
            chk("wr_stall", {63'd0, cpu_stall}, 64'd0);
            chk("wr_wreq", {56'd0, fill_wreq}, 64'd0);
            chk("wr_valid", {56'd0, line_valid}, 64'h01);
            step();
        end
        cpu_wreq  = 1'b0;
        ack_force = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
